frame_burst_arbiter: RTL and testbench
======================================

# frame_burst_arbiter

Multi-channel burst arbiter that lets CHANNELS independent frame read/write controller pairs share one external memory controller port on mem_clk. Each channel presents read and write burst requests in the same req/len/addr/finish handshake the memory controller uses. The arbiter grants one burst at a time, either round-robin or fixed-priority, and routes the data strobes, write data and finish back to the granted channel. It sits between the per-channel frame read/write blocks and the memory controller.

## Interface
- CHANNELS, 4: number of channel pairs, 1..8; gives 2*CHANNELS request slots.
- MEM_DATA_BITS, 16: memory data width.
- ADDR_BITS, 24: burst address width.
- BUSRT_BITS, 10: burst length width.
- PRIORITY_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest slot wins).
- SW = $clog2(2*CHANNELS): slot index width (localparam).

Ports:
- mem_clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- ch_rd_burst_req  in  CHANNELS  per-channel read burst request.
- ch_rd_burst_len  in  CHANNELS*BUSRT_BITS  packed read lengths, channel c at [c*BUSRT_BITS +: BUSRT_BITS].
- ch_rd_burst_addr  in  CHANNELS*ADDR_BITS  packed read addresses.
- ch_rd_burst_data_valid  out  CHANNELS  read data valid, granted channel only.
- ch_rd_burst_finish  out  CHANNELS  read burst finish pulse.
- ch_wr_burst_req  in  CHANNELS  per-channel write burst request.
- ch_wr_burst_len  in  CHANNELS*BUSRT_BITS  packed write lengths.
- ch_wr_burst_addr  in  CHANNELS*ADDR_BITS  packed write addresses.
- ch_wr_burst_data_req  out  CHANNELS  write data request, granted channel only.
- ch_wr_burst_data  in  CHANNELS*MEM_DATA_BITS  packed write data.
- ch_wr_burst_finish  out  CHANNELS  write burst finish pulse.
- rd_burst_req / rd_burst_len / rd_burst_addr  out  1/BUSRT_BITS/ADDR_BITS  to memory controller.
- rd_burst_data_valid, rd_burst_finish  in  1  from memory controller. Read data is not routed by the arbiter; it is broadcast outside this block.
- wr_burst_req / wr_burst_len / wr_burst_addr  out  1/BUSRT_BITS/ADDR_BITS  to memory controller.
- wr_burst_data_req, wr_burst_finish  in  1  from memory controller.
- wr_burst_data  out  MEM_DATA_BITS  muxed write data.
- grant_valid  out  1  a burst is in progress.
- grant_slot  out  SW  slot being served.

## Operation
- Slot mapping: slot 2c is the read request of channel c; slot 2c+1 is the write request of channel c.
- States:
  - IDLE: sample all requests. If none are asserted, stay in IDLE. Otherwise pick a winner, latch its len/addr, then:
    - len != 0: go to RD or WR.
    - len == 0: go to ZERO.
  - RD: rd_burst_req=1. Wait for rd_burst_finish, then go to GAP.
  - WR: wr_burst_req=1. Wait for wr_burst_finish, then go to GAP.
  - ZERO: issue no memory request. Pulse the slot's ch_*_finish for one cycle, then go to GAP.
  - GAP: one idle cycle so the served channel can drop its req, then go to IDLE.
- Round-robin: search slots last+1 … last+2*CHANNELS modulo 2*CHANNELS. Update last on every grant. last resets to 2*CHANNELS-1, so slot 0 wins first.
- Fixed priority: lowest asserted slot wins; last is ignored.
- Routing during RD/WR, combinational, gated by the granted slot:
  - ch_rd_burst_data_valid[c] = rd_burst_data_valid.
  - ch_rd_burst_finish[c] = rd_burst_finish.
  - ch_wr_burst_data_req[c] = wr_burst_data_req.
  - ch_wr_burst_finish[c] = wr_burst_finish.
  - wr_burst_data = ch_wr_burst_data of the granted channel in WR, else 0.
  - All other channels see 0.
- Requests are sampled only in IDLE. A req that rises and falls outside IDLE is never served. Memory strobes arriving in IDLE or GAP are ignored.

## Timing
- Reset (asynchronous, any state, including mid-burst): state=IDLE, last=2*CHANNELS-1, all outputs 0.
- Request seen in IDLE at cycle t: grant_valid, grant_slot, *_burst_req, len and addr are registered and valid at t+1. Len/addr stay stable until finish.
- Finish at cycle f: ch finish pulses at f (same cycle). *_burst_req and grant_valid are 0 at f+1 (GAP). Back in IDLE at f+2. Earliest next memory req at f+3.
- Zero-length grant: ch finish at t+1, GAP at t+2, IDLE at t+3.
- Finish asserted on the same cycle as the memory controller's last data_valid/data_req is legal; both are routed in that cycle.
- All memory-side request outputs are registered. The channel-side strobes and wr_burst_data are combinational from the memory controller.

## Structure
- Package frame_arb_pkg:
  - state enum {IDLE, RD, WR, ZERO, GAP};
  - slot-to-channel and slot-is-write helper functions.
- Sub-module rr_pick (parameters N, MODE): request vector plus last index in, winner index plus found out; purely combinational.
- Top block: FSM, latches, routing.

## Test plan
- Single read: ch1 rd req, len=16, addr=0x000100 → rd_burst_req at t+1 with len 16, addr 0x000100, grant_slot=2. 16 data_valid pulses reach only ch_rd_burst_data_valid[1]. Finish pulses ch_rd_burst_finish[1].
- Round-robin: all 8 slots request continuously with len=4 (CHANNELS=4) → grant order 0,1,2…7,0, each memory req starting 3 cycles after the previous finish.
- Fixed priority (PRIORITY_MODE=1): slots 5 and 2 requesting repeatedly → slot 2 is always served while asserted; slot 5 is served only after slot 2 drops.
- Write mux: ch3 wr, len=8, ch_wr_burst_data[3]=0xA5A5, other channels 0xFFFF → wr_burst_data=0xA5A5 while in WR. Only ch_wr_burst_data_req[3] toggles.
- Zero length: ch0 wr len=0 → no wr_burst_req, ch_wr_burst_finish[0] high for exactly one cycle at t+1.
- Reset mid-burst: rst asserted during RD after 5 of 16 data → all outputs 0 immediately. After release, slot 0 is granted first.

Source files
------------

// File: rtl/frame_arb_pkg.sv
// Shared state encoding and slot helpers for the frame burst arbiter.
// Slot 2c is channel c's read request, slot 2c+1 is its write request.
package frame_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        ZERO,
        GAP
    } arb_state_e;

    function automatic int unsigned slot_ch(input int unsigned slot);
        return slot >> 1;
    endfunction

    function automatic logic slot_is_wr(input int unsigned slot);
        return slot[0];
    endfunction

endpackage

// File: rtl/frame_burst_arbiter_rr_pick.sv
// Combinational winner select: round-robin after 'last' (MODE=0) or lowest slot (MODE=1).
// Zero latency; no handshake, the caller samples win/found when it is ready to grant.
module rr_pick #(
    parameter  int N    = 8,
    parameter  int MODE = 0,
    localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] last,
    output logic [SW-1:0] win,
    output logic          found
);

    logic [SW-1:0] idx;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        if (MODE != 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                idx = SW'(i);
                if (req[idx]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end else begin
            for (int k = N; k >= 1; k--) begin
                idx = SW'((int'(last) + k) % N);
                if (req[idx]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/frame_burst_arbiter.sv
// Shares one memory controller port between CHANNELS read/write slot pairs, one burst at a time.
// Grant and memory requests registered one cycle after IDLE sampling; strobes routed combinationally.
module frame_burst_arbiter
    import frame_arb_pkg::*;
#(
    parameter  int CHANNELS      = 4,
    parameter  int MEM_DATA_BITS = 16,
    parameter  int ADDR_BITS     = 24,
    parameter  int BUSRT_BITS    = 10,
    parameter  int PRIORITY_MODE = 0,
    localparam int NS            = 2 * CHANNELS,
    localparam int SW            = $clog2(2 * CHANNELS)
) (
    input  logic                              mem_clk,
    input  logic                              rst,

    input  logic [CHANNELS-1:0]               ch_rd_burst_req,
    input  logic [CHANNELS*BUSRT_BITS-1:0]    ch_rd_burst_len,
    input  logic [CHANNELS*ADDR_BITS-1:0]     ch_rd_burst_addr,
    output logic [CHANNELS-1:0]               ch_rd_burst_data_valid,
    output logic [CHANNELS-1:0]               ch_rd_burst_finish,

    input  logic [CHANNELS-1:0]               ch_wr_burst_req,
    input  logic [CHANNELS*BUSRT_BITS-1:0]    ch_wr_burst_len,
    input  logic [CHANNELS*ADDR_BITS-1:0]     ch_wr_burst_addr,
    output logic [CHANNELS-1:0]               ch_wr_burst_data_req,
    input  logic [CHANNELS*MEM_DATA_BITS-1:0] ch_wr_burst_data,
    output logic [CHANNELS-1:0]               ch_wr_burst_finish,

    output logic                              rd_burst_req,
    output logic [BUSRT_BITS-1:0]             rd_burst_len,
    output logic [ADDR_BITS-1:0]              rd_burst_addr,
    input  logic                              rd_burst_data_valid,
    input  logic                              rd_burst_finish,

    output logic                              wr_burst_req,
    output logic [BUSRT_BITS-1:0]             wr_burst_len,
    output logic [ADDR_BITS-1:0]              wr_burst_addr,
    input  logic                              wr_burst_data_req,
    output logic [MEM_DATA_BITS-1:0]          wr_burst_data,
    input  logic                              wr_burst_finish,

    output logic                              grant_valid,
    output logic [SW-1:0]                     grant_slot
);

    arb_state_e            state_q, state_d;
    logic [SW-1:0]         last_q, last_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic                  gv_q, gv_d;
    logic                  rd_req_q, rd_req_d;
    logic [BUSRT_BITS-1:0] rd_len_q, rd_len_d;
    logic [ADDR_BITS-1:0]  rd_addr_q, rd_addr_d;
    logic                  wr_req_q, wr_req_d;
    logic [BUSRT_BITS-1:0] wr_len_q, wr_len_d;
    logic [ADDR_BITS-1:0]  wr_addr_q, wr_addr_d;

    logic [NS-1:0]         req_vec;
    logic [SW-1:0]         win;
    logic                  found;
    logic [BUSRT_BITS-1:0] win_len;
    logic [ADDR_BITS-1:0]  win_addr;

    always_comb begin
        req_vec = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            req_vec[2*c]     = ch_rd_burst_req[c];
            req_vec[2*c + 1] = ch_wr_burst_req[c];
        end
    end

    rr_pick #(
        .N    (NS),
        .MODE (PRIORITY_MODE)
    ) u_pick (
        .req   (req_vec),
        .last  (last_q),
        .win   (win),
        .found (found)
    );

    always_comb begin
        win_len  = '0;
        win_addr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(slot_ch(32'(win))) == c) begin
                if (slot_is_wr(32'(win))) begin
                    win_len  = ch_wr_burst_len[c*BUSRT_BITS +: BUSRT_BITS];
                    win_addr = ch_wr_burst_addr[c*ADDR_BITS +: ADDR_BITS];
                end else begin
                    win_len  = ch_rd_burst_len[c*BUSRT_BITS +: BUSRT_BITS];
                    win_addr = ch_rd_burst_addr[c*ADDR_BITS +: ADDR_BITS];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        slot_d    = slot_q;
        gv_d      = gv_q;
        rd_req_d  = rd_req_q;
        rd_len_d  = rd_len_q;
        rd_addr_d = rd_addr_q;
        wr_req_d  = wr_req_q;
        wr_len_d  = wr_len_q;
        wr_addr_d = wr_addr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    slot_d = win;
                    last_d = win;
                    gv_d   = 1'b1;
                    if (win_len == '0) begin
                        state_d = ZERO;
                    end else if (slot_is_wr(32'(win))) begin
                        state_d   = WR;
                        wr_req_d  = 1'b1;
                        wr_len_d  = win_len;
                        wr_addr_d = win_addr;
                    end else begin
                        state_d   = RD;
                        rd_req_d  = 1'b1;
                        rd_len_d  = win_len;
                        rd_addr_d = win_addr;
                    end
                end
            end
            RD: begin
                if (rd_burst_finish) begin
                    state_d   = GAP;
                    gv_d      = 1'b0;
                    rd_req_d  = 1'b0;
                    rd_len_d  = '0;
                    rd_addr_d = '0;
                end
            end
            WR: begin
                if (wr_burst_finish) begin
                    state_d   = GAP;
                    gv_d      = 1'b0;
                    wr_req_d  = 1'b0;
                    wr_len_d  = '0;
                    wr_addr_d = '0;
                end
            end
            ZERO: begin
                state_d = GAP;
                gv_d    = 1'b0;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= SW'(NS - 1);
            slot_q    <= '0;
            gv_q      <= 1'b0;
            rd_req_q  <= 1'b0;
            rd_len_q  <= '0;
            rd_addr_q <= '0;
            wr_req_q  <= 1'b0;
            wr_len_q  <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            slot_q    <= slot_d;
            gv_q      <= gv_d;
            rd_req_q  <= rd_req_d;
            rd_len_q  <= rd_len_d;
            rd_addr_q <= rd_addr_d;
            wr_req_q  <= wr_req_d;
            wr_len_q  <= wr_len_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    // Strobes in IDLE/GAP fall through here as zeros, so stray controller pulses are dropped.
    always_comb begin
        ch_rd_burst_data_valid = '0;
        ch_rd_burst_finish     = '0;
        ch_wr_burst_data_req   = '0;
        ch_wr_burst_finish     = '0;
        wr_burst_data          = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(slot_ch(32'(slot_q))) == c) begin
                if (state_q == RD) begin
                    ch_rd_burst_data_valid[c] = rd_burst_data_valid;
                    ch_rd_burst_finish[c]     = rd_burst_finish;
                end
                if (state_q == WR) begin
                    ch_wr_burst_data_req[c] = wr_burst_data_req;
                    ch_wr_burst_finish[c]   = wr_burst_finish;
                    wr_burst_data           = ch_wr_burst_data[c*MEM_DATA_BITS +: MEM_DATA_BITS];
                end
                if (state_q == ZERO) begin
                    if (slot_is_wr(32'(slot_q))) begin
                        ch_wr_burst_finish[c] = 1'b1;
                    end else begin
                        ch_rd_burst_finish[c] = 1'b1;
                    end
                end
            end
        end
    end

    assign rd_burst_req  = rd_req_q;
    assign rd_burst_len  = rd_len_q;
    assign rd_burst_addr = rd_addr_q;
    assign wr_burst_req  = wr_req_q;
    assign wr_burst_len  = wr_len_q;
    assign wr_burst_addr = wr_addr_q;
    assign grant_valid   = gv_q;
    assign grant_slot    = slot_q;

endmodule

// File: tb/tb_frame_burst_arbiter.sv
// Bench for frame_burst_arbiter: instance 0 round-robin, instance 1 fixed priority.
module tb_frame_burst_arbiter;

    localparam int CH = 4;
    localparam int NS = 8;
    localparam int LB = 10;
    localparam int AB = 24;
    localparam int DB = 16;

    logic mem_clk = 1'b0;
    logic rst;
    always #5 mem_clk = ~mem_clk;

    logic [CH-1:0]    rd_req, wr_req;
    logic [CH*LB-1:0] rd_len, wr_len;
    logic [CH*AB-1:0] rd_addr, wr_addr;
    logic [CH*DB-1:0] wr_dat;

    logic             m_rd_dv[2], m_rd_fin[2], m_wr_dreq[2], m_wr_fin[2];
    logic [CH-1:0]    o_rd_dv[2], o_rd_fin[2], o_wr_dreq[2], o_wr_fin[2];
    logic             o_rd_req[2], o_wr_req[2], o_gv[2];
    logic [LB-1:0]    o_rd_len[2], o_wr_len[2];
    logic [AB-1:0]    o_rd_addr[2], o_wr_addr[2];
    logic [DB-1:0]    o_wr_dat[2];
    logic [2:0]       o_slot[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        frame_burst_arbiter #(
            .CHANNELS(CH), .MEM_DATA_BITS(DB), .ADDR_BITS(AB),
            .BUSRT_BITS(LB), .PRIORITY_MODE(g)
        ) u_dut (
            .mem_clk                (mem_clk),
            .rst                    (rst),
            .ch_rd_burst_req        (rd_req),
            .ch_rd_burst_len        (rd_len),
            .ch_rd_burst_addr       (rd_addr),
            .ch_rd_burst_data_valid (o_rd_dv[g]),
            .ch_rd_burst_finish     (o_rd_fin[g]),
            .ch_wr_burst_req        (wr_req),
            .ch_wr_burst_len        (wr_len),
            .ch_wr_burst_addr       (wr_addr),
            .ch_wr_burst_data_req   (o_wr_dreq[g]),
            .ch_wr_burst_data       (wr_dat),
            .ch_wr_burst_finish     (o_wr_fin[g]),
            .rd_burst_req           (o_rd_req[g]),
            .rd_burst_len           (o_rd_len[g]),
            .rd_burst_addr          (o_rd_addr[g]),
            .rd_burst_data_valid    (m_rd_dv[g]),
            .rd_burst_finish        (m_rd_fin[g]),
            .wr_burst_req           (o_wr_req[g]),
            .wr_burst_len           (o_wr_len[g]),
            .wr_burst_addr          (o_wr_addr[g]),
            .wr_burst_data_req      (m_wr_dreq[g]),
            .wr_burst_data          (o_wr_dat[g]),
            .wr_burst_finish        (m_wr_fin[g]),
            .grant_valid            (o_gv[g]),
            .grant_slot             (o_slot[g])
        );
    end

    int n_cmp;
    int n_err;
    int m_len[NS];
    int m_addr[NS];
    int m_wdat[CH];
    int last_m[2];

    typedef struct {
        logic [CH-1:0] rd;
        logic [CH-1:0] wr;
        int            slot;
        logic          exp_rd;
        logic          exp_wr;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_slot(input int s, input bit on, input int len, input int addr);
        int c;
        c = s / 2;
        if (s % 2 == 1) begin
            wr_req[c] = on;
            wr_len[c*LB +: LB] = LB'(len);
            wr_addr[c*AB +: AB] = AB'(addr);
        end else begin
            rd_req[c] = on;
            rd_len[c*LB +: LB] = LB'(len);
            rd_addr[c*AB +: AB] = AB'(addr);
        end
        m_len[s] = len;
        m_addr[s] = addr;
    endtask

    task automatic set_wdat(input int c, input int val);
        wr_dat[c*DB +: DB] = DB'(val);
        m_wdat[c] = val & 16'hFFFF;
    endtask

    task automatic clear_all();
        for (int s = 0; s < NS; s++) set_slot(s, 1'b0, 5, 0);
    endtask

    task automatic strobes(input int inst, input bit dv, input bit rf, input bit dq, input bit wf);
        m_rd_dv[inst] = dv;
        m_rd_fin[inst] = rf;
        m_wr_dreq[inst] = dq;
        m_wr_fin[inst] = wf;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        strobes(0, 0, 0, 0, 0);
        strobes(1, 0, 0, 0, 0);
        @(negedge mem_clk);
        @(negedge mem_clk);
        rst = 1'b0;
        last_m[0] = NS - 1;
        last_m[1] = NS - 1;
    endtask

    function automatic logic [NS-1:0] req_vec();
        logic [NS-1:0] v;
        for (int c = 0; c < CH; c++) begin
            v[2*c] = rd_req[c];
            v[2*c+1] = wr_req[c];
        end
        return v;
    endfunction

    // Reference arbitration straight from the slot-ordering rules.
    function automatic int pick(input logic [NS-1:0] v, input int last, input int mode);
        if (mode == 1) begin
            for (int i = 0; i < NS; i++) if (v[i]) return i;
        end else begin
            for (int k = 1; k <= NS; k++) if (v[(last + k) % NS]) return (last + k) % NS;
        end
        return -1;
    endfunction

    // Enters at an IDLE negedge with requests set; returns at the next IDLE negedge.
    task automatic burst(input int inst, input int s);
        int c, len, left;
        bit isw, pulse, fin;
        logic [CH-1:0] oh;
        c = s / 2;
        isw = (s % 2 == 1);
        len = m_len[s];
        oh = '0;
        oh[c] = 1'b1;
        @(negedge mem_clk);
        chk("grant_valid", o_gv[inst], 1);
        chk("grant_slot", o_slot[inst], s);
        if (len == 0) begin
            chk("zero_no_rd_req", o_rd_req[inst], 0);
            chk("zero_no_wr_req", o_wr_req[inst], 0);
            chk("zero_fin", isw ? o_wr_fin[inst] : o_rd_fin[inst], oh);
            chk("zero_other_fin", isw ? o_rd_fin[inst] : o_wr_fin[inst], 0);
            @(negedge mem_clk);
            chk("zero_fin_gap", o_rd_fin[inst] | o_wr_fin[inst], 0);
            chk("zero_gap_gv", o_gv[inst], 0);
            @(negedge mem_clk);
        end else begin
            chk("rd_req", o_rd_req[inst], !isw);
            chk("wr_req", o_wr_req[inst], isw);
            chk("len", isw ? o_wr_len[inst] : o_rd_len[inst], len);
            chk("addr", isw ? o_wr_addr[inst] : o_rd_addr[inst], m_addr[s]);
            left = len;
            while (left > 0) begin
                pulse = ($urandom_range(0, 3) != 0);
                if (pulse) left--;
                fin = (left == 0);
                if (isw) strobes(inst, 0, 0, pulse, fin);
                else strobes(inst, pulse, fin, 0, 0);
                #1;
                chk("req_held", isw ? o_wr_req[inst] : o_rd_req[inst], 1);
                if (isw) begin
                    chk("ch_wr_dreq", o_wr_dreq[inst], pulse ? oh : '0);
                    chk("ch_wr_fin", o_wr_fin[inst], fin ? oh : '0);
                    chk("wr_data_mux", o_wr_dat[inst], m_wdat[c]);
                    chk("rd_side_quiet", o_rd_dv[inst] | o_rd_fin[inst], 0);
                end else begin
                    chk("ch_rd_dv", o_rd_dv[inst], pulse ? oh : '0);
                    chk("ch_rd_fin", o_rd_fin[inst], fin ? oh : '0);
                    chk("wr_data_zero_rd", o_wr_dat[inst], 0);
                    chk("wr_side_quiet", o_wr_dreq[inst] | o_wr_fin[inst], 0);
                end
                @(negedge mem_clk);
            end
            strobes(inst, 1, 1, 1, 1);
            #1;
            chk("gap_req_low", {o_rd_req[inst], o_wr_req[inst]}, 0);
            chk("gap_gv_low", o_gv[inst], 0);
            chk("gap_strobes_dropped", {o_rd_dv[inst], o_rd_fin[inst], o_wr_dreq[inst], o_wr_fin[inst]}, 0);
            @(negedge mem_clk);
            chk("idle_strobes_dropped", {o_rd_dv[inst], o_rd_fin[inst], o_wr_dreq[inst], o_wr_fin[inst]}, 0);
            strobes(inst, 0, 0, 0, 0);
        end
    endtask

    task automatic serve(input int inst);
        int s;
        s = pick(req_vec(), last_m[inst], inst);
        if (s < 0) begin
            @(negedge mem_clk);
            chk("no_req_no_grant", o_gv[inst], 0);
        end else begin
            last_m[inst] = s;
            burst(inst, s);
        end
    endtask

    initial begin
        vec_t tbl[5];
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        rd_req = '0; wr_req = '0; rd_len = '0; wr_len = '0;
        rd_addr = '0; wr_addr = '0; wr_dat = '0;
        strobes(0, 0, 0, 0, 0);
        strobes(1, 0, 0, 0, 0);
        for (int c = 0; c < CH; c++) set_wdat(c, 16'hFFFF);

        tbl[0] = '{rd: 4'b0010, wr: 4'b0000, slot: 2, exp_rd: 1'b1, exp_wr: 1'b0};
        tbl[1] = '{rd: 4'b0000, wr: 4'b1000, slot: 7, exp_rd: 1'b0, exp_wr: 1'b1};
        tbl[2] = '{rd: 4'b0100, wr: 4'b0010, slot: 3, exp_rd: 1'b0, exp_wr: 1'b1};
        tbl[3] = '{rd: 4'b1000, wr: 4'b1000, slot: 6, exp_rd: 1'b1, exp_wr: 1'b0};
        tbl[4] = '{rd: 4'b1111, wr: 4'b1111, slot: 0, exp_rd: 1'b1, exp_wr: 1'b0};

        @(negedge mem_clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_gv", o_gv[i], 0);
            chk("rst_slot", o_slot[i], 0);
            chk("rst_reqs", {o_rd_req[i], o_wr_req[i]}, 0);
            chk("rst_len_addr", {o_rd_len[i], o_rd_addr[i]} | {o_wr_len[i], o_wr_addr[i]}, 0);
            chk("rst_ch_out", {o_rd_dv[i], o_rd_fin[i], o_wr_dreq[i], o_wr_fin[i]}, 0);
            chk("rst_wr_data", o_wr_dat[i], 0);
        end

        // First grant after reset for a few request patterns, both modes.
        for (int v = 0; v < 5; v++) begin
            clear_all();
            for (int c = 0; c < CH; c++) begin
                set_slot(2*c, tbl[v].rd[c], 5, 32'h1000 + c);
                set_slot(2*c+1, tbl[v].wr[c], 5, 32'h2000 + c);
            end
            do_reset();
            @(negedge mem_clk);
            for (int i = 0; i < 2; i++) begin
                chk("tbl_gv", o_gv[i], 1);
                chk("tbl_slot", o_slot[i], tbl[v].slot);
                chk("tbl_rd_req", o_rd_req[i], tbl[v].exp_rd);
                chk("tbl_wr_req", o_wr_req[i], tbl[v].exp_wr);
            end
        end

        // Single read, write mux, zero-length write on the round-robin instance.
        clear_all();
        set_slot(2, 1'b1, 16, 32'h000100);
        do_reset();
        serve(0);
        set_slot(2, 1'b0, 16, 32'h000100);
        serve(0);
        set_wdat(3, 16'hA5A5);
        set_slot(7, 1'b1, 8, 32'h002000);
        serve(0);
        set_slot(7, 1'b0, 8, 32'h002000);
        set_slot(1, 1'b1, 0, 32'h0);
        serve(0);
        set_slot(1, 1'b0, 0, 32'h0);
        serve(0);

        // All slots requesting continuously: full rotation and wrap.
        for (int s = 0; s < NS; s++) set_slot(s, 1'b1, 4, 32'h10 * s);
        do_reset();
        for (int k = 0; k < NS + 1; k++) serve(0);

        // Reset in the middle of a read burst.
        clear_all();
        set_slot(4, 1'b1, 16, 32'h000300);
        do_reset();
        @(negedge mem_clk);
        chk("mid_grant_slot", o_slot[0], 4);
        for (int k = 0; k < 5; k++) begin
            m_rd_dv[0] = 1'b1;
            #1;
            chk("mid_ch_rd_dv", o_rd_dv[0], 4'b0100);
            @(negedge mem_clk);
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_req", o_rd_req[0], 0);
        chk("mid_rst_len_addr", {o_rd_len[0], o_rd_addr[0]}, 0);
        chk("mid_rst_gv", o_gv[0], 0);
        chk("mid_rst_slot", o_slot[0], 0);
        chk("mid_rst_ch_dv", o_rd_dv[0], 0);
        for (int s = 0; s < NS; s++) set_slot(s, 1'b1, 3, 32'h500 + s);
        @(negedge mem_clk);
        strobes(0, 0, 0, 0, 0);
        rst = 1'b0;
        last_m[0] = NS - 1;
        last_m[1] = NS - 1;
        serve(0);

        // Fixed priority: slot 2 starves slot 5 until it drops.
        clear_all();
        set_slot(2, 1'b1, 3, 32'h40);
        set_slot(5, 1'b1, 2, 32'h50);
        do_reset();
        for (int k = 0; k < 3; k++) serve(1);
        set_slot(2, 1'b0, 3, 32'h40);
        serve(1);

        // Randomized traffic against the reference arbitration model.
        for (int inst = 0; inst < 2; inst++) begin
            clear_all();
            do_reset();
            for (int it = 0; it < 30; it++) begin
                for (int s = 0; s < NS; s++)
                    set_slot(s, 1'($urandom_range(0, 1)),
                             ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6)),
                             int'($urandom_range(0, 24'hFFFFFF)));
                for (int c = 0; c < CH; c++) set_wdat(c, int'($urandom_range(0, 16'hFFFF)));
                serve(inst);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
